// File: rtl/ysyx_25060170_pkg.sv
// ysyx_25060170_pkg -- shared types and defaults for the instruction fetch unit.
// Revision 1.0
`default_nettype none

package ysyx_25060170_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25060170_ifu_perf.sv
// ============================================================================
// Module   : ysyx_25060170_ifu_perf
// Brief    : delivered-instruction and stall counters, only built with
//            YSYX_25060170_IFU_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifdef YSYX_25060170_IFU_PERF_EN
module ysyx_25060170_ifu_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_fetch_fire,
    input  logic        i_stall,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_stall_cnt
);

    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= 32'h0;
            r_stall_cnt <= 32'h0;
        end else begin
            if (i_fetch_fire) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (i_stall)      r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_stall_cnt = r_stall_cnt;

    task IFU_SEND_PERF(output int fetch, output int stall);
        fetch = int'(r_fetch_cnt);
        stall = int'(r_stall_cnt);
    endtask

endmodule
`endif

`default_nettype wire

// File: rtl/ysyx_25060170_ifu_fetch.sv
// ysyx_25060170_ifu_fetch -- fetch FSM, PC and decode-side output registers.
// Optional perf counters with YSYX_25060170_IFU_PERF_EN. Revision 1.0
`default_nettype none

module ysyx_25060170_ifu_fetch
  import ysyx_25060170_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_err_o,
  output logic [XLEN-1:0] perf_fetch_cnt_o,
  output logic [XLEN-1:0] perf_stall_cnt_o
);

  ifu_state_t      r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_addr, w_addr_nxt;
  logic            r_kill, w_kill_nxt;
  logic            w_latch;
  logic [XLEN-1:0] r_inst, r_pc_o;
  logic            r_err;
  logic [XLEN-1:0] w_target;
  logic            w_unused_lo;

  assign w_target    = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_unused_lo = ^redirect_pc_i[1:0];

  // r_addr is kept apart from r_pc so an unaccepted request holds its address across a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_kill_nxt  = r_kill;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = REQ;
        w_addr_nxt  = r_pc;
      end
      REQ: begin
        if (redirect_valid_i) begin
          w_pc_nxt   = w_target;
          w_kill_nxt = 1'b1;
        end
        if (imem_req_ready_i) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (redirect_valid_i) begin
          w_pc_nxt = w_target;
          if (imem_rsp_valid_i) begin
            w_state_nxt = REQ;
            w_addr_nxt  = w_target;
            w_kill_nxt  = 1'b0;
          end else begin
            w_kill_nxt  = 1'b1;
          end
        end else if (imem_rsp_valid_i) begin
          if (r_kill) begin
            w_state_nxt = REQ;
            w_addr_nxt  = r_pc;
            w_kill_nxt  = 1'b0;
          end else begin
            w_state_nxt = HOLD;
            w_latch     = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect_valid_i) begin
          w_state_nxt = REQ;
          w_pc_nxt    = w_target;
          w_addr_nxt  = w_target;
        end else if (inst_ready_i) begin
          w_state_nxt = REQ;
          w_pc_nxt    = seq_pc(r_pc);
          w_addr_nxt  = seq_pc(r_pc);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst <= '0;
      r_pc_o <= RESET_PC;
      r_err  <= 1'b0;
    end else if (w_latch) begin
      r_inst <= imem_rsp_err_i ? NOP_INST : imem_rsp_data_i;
      r_pc_o <= r_pc;
      r_err  <= imem_rsp_err_i;
    end else if ((r_state == HOLD) && (w_state_nxt != HOLD)) begin
      r_err  <= 1'b0;
    end
  end

  assign imem_req_valid_o = (r_state == REQ);
  assign imem_req_addr_o  = r_addr;
  assign inst_valid_o     = (r_state == HOLD);
  assign inst_o           = r_inst;
  assign pc_o             = r_pc_o;
  assign fetch_err_o      = r_err;

`ifdef YSYX_25060170_IFU_PERF_EN
  logic w_fire;
  logic w_stall;

  assign w_fire  = inst_valid_o & inst_ready_i;
  assign w_stall = (r_state == REQ) || (r_state == WAIT);

  ysyx_25060170_ifu_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .i_fetch_fire (w_fire),
    .i_stall      (w_stall),
    .o_fetch_cnt  (perf_fetch_cnt_o),
    .o_stall_cnt  (perf_stall_cnt_o)
  );
`else
  assign perf_fetch_cnt_o = 32'h0;
  assign perf_stall_cnt_o = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25060170_ifu_fetch.sv
// tb_ysyx_25060170_ifu_fetch -- directed stimulus with a delivery scoreboard and memory model.
// Revision 1.0
`default_nettype none

module tb_ysyx_25060170_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        fetch_err_o;
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;

  ysyx_25060170_ifu_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .fetch_err_o      (fetch_err_o),
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  logic        mem_ready_cfg = 1'b1;
  int          rsp_delay     = 0;
  logic [31:0] fault_addr    = 32'h1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Memory: word = 0x00100093 ^ (addr << 8), response rsp_delay cycles after the WAIT entry.
  initial begin
    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_addr;
    m_pend = 1'b0; m_cnt = 0; m_addr = '0;
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0; imem_rsp_err_i = 1'b0; imem_req_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
      imem_rsp_err_i   = 1'b0;
      if (rst) begin
        m_pend = 1'b0;
      end else if (m_pend) begin
        if (m_cnt == 0) begin
          imem_rsp_valid_i = 1'b1;
          imem_rsp_data_i  = 32'h0010_0093 ^ (m_addr << 8);
          imem_rsp_err_i   = (m_addr == fault_addr);
          m_pend = 1'b0;
        end else begin
          m_cnt--;
        end
      end
      imem_req_ready_i = mem_ready_cfg;
      if (!rst && !m_pend && imem_req_valid_o && imem_req_ready_i) begin
        m_pend = 1'b1;
        m_addr = imem_req_addr_o;
        m_cnt  = rsp_delay;
      end
    end
  end

  // Monitor: every decode handshake must match the oldest expected delivery.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst !== 1'b0) continue;
      if (inst_valid_o && inst_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual_pc=%h required=none", pc_o);
        end else begin
          e = sb.pop_front();
          chk("deliver_pc", pc_o, e.pc);
          chk("deliver_inst", inst_o, e.inst);
          chk("deliver_err", {31'b0, fetch_err_o}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic err);
    sb.push_back('{pc, inst, err});
  endtask

  task automatic wait_hold();
    int n = 0;
    while (!inst_valid_o && n < 30) begin tick(); n++; end
    chk("wait_hold", {31'b0, inst_valid_o}, 32'd1);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid_o && n < 30) begin tick(); n++; end
    chk("wait_req", {31'b0, imem_req_valid_o}, 32'd1);
  endtask

  task automatic consume(input logic redir, input logic [31:0] target);
    wait_hold();
    inst_ready_i     = 1'b1;
    redirect_valid_i = redir;
    redirect_pc_i    = target;
    tick();
    inst_ready_i     = 1'b0;
    redirect_valid_i = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, {31'b0, imem_req_valid_o}, 32'd0);
    chk({tag, "_inst_valid"}, {31'b0, inst_valid_o}, 32'd0);
    chk({tag, "_inst"}, inst_o, 32'h0);
    chk({tag, "_pc"}, pc_o, 32'h8000_0000);
    chk({tag, "_err"}, {31'b0, fetch_err_o}, 32'd0);
    chk({tag, "_addr"}, imem_req_addr_o, 32'h8000_0000);
    chk({tag, "_perf_fetch"}, perf_fetch_cnt_o, 32'h0);
    chk({tag, "_perf_stall"}, perf_stall_cnt_o, 32'h0);
  endtask

  localparam logic [31:0] SEQ_DATA [10] = '{
    32'h0010_0093, 32'h0010_0493, 32'h0010_0893, 32'h0010_0C93, 32'h0010_1093,
    32'h0010_1493, 32'h0010_1893, 32'h0010_1C93, 32'h0010_2093, 32'h0010_2493
  };

  initial begin
    int lat;
    rst = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0; inst_ready_i = 1'b0;
    repeat (3) tick();
    #1;
    chk_reset("reset");

    // First fetch latency and request address.
    tick();
    rst = 1'b0;
    lat = 0;
    while (!inst_valid_o && lat < 20) begin
      tick();
      lat++;
      if (lat == 1) begin
        chk("first_req_valid", {31'b0, imem_req_valid_o}, 32'd1);
        chk("first_req_addr", imem_req_addr_o, 32'h8000_0000);
      end
    end
    chk("first_latency", lat, 3);
    push(32'h8000_0000, 32'h0010_0093, 1'b0);

    // Decode stall: outputs hold, no new request.
    repeat (5) begin
      chk("hold_inst", inst_o, 32'h0010_0093);
      chk("hold_pc", pc_o, 32'h8000_0000);
      chk("hold_no_req", {30'b0, imem_req_valid_o, inst_valid_o}, 32'd1);
      tick();
    end
    consume(1'b0, 32'h0);
    wait_req();
    chk("seq_addr", imem_req_addr_o, 32'h8000_0004);

    // Redirect with handshake (unaligned target), then redirect while WAIT drops the response.
    push(32'h8000_0004, 32'h0010_0493, 1'b0);
    rsp_delay = 2;
    consume(1'b1, 32'h8000_0103);
    wait_req();
    chk("redir_addr", imem_req_addr_o, 32'h8000_0100);
    tick();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0008; fault_addr = 32'h8000_0008;
    tick();
    redirect_valid_i = 1'b0; rsp_delay = 0;
    push(32'h8000_0008, 32'h0000_0013, 1'b1);
    consume(1'b0, 32'h0);
    wait_req();
    chk("after_err_addr", imem_req_addr_o, 32'h8000_000C);
    fault_addr = 32'h1;

    // Wrap at the top of the address space; next request held back by memory.
    push(32'h8000_000C, 32'h0010_0C93, 1'b0);
    consume(1'b1, 32'hFFFF_FFFE);
    push(32'hFFFF_FFFC, 32'hFFEF_FC93, 1'b0);
    mem_ready_cfg = 1'b0;
    consume(1'b0, 32'h0);
    wait_req();
    chk("wrap_addr", imem_req_addr_o, 32'h0000_0000);

    // Redirect while the request is unaccepted: address holds, its response is dropped.
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0040;
    tick();
    redirect_valid_i = 1'b0;
    chk("req_stable_valid", {31'b0, imem_req_valid_o}, 32'd1);
    chk("req_stable_addr", imem_req_addr_o, 32'h0000_0000);
    tick();
    chk("req_stable_addr2", imem_req_addr_o, 32'h0000_0000);
    mem_ready_cfg = 1'b1;
    push(32'h8000_0040, 32'h0010_4093, 1'b0);
    consume(1'b0, 32'h0);

    // Redirect in HOLD without decode ready: held word discarded.
    wait_hold();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0080;
    tick();
    redirect_valid_i = 1'b0;
    chk("hold_discard_valid", {31'b0, inst_valid_o}, 32'd0);
    push(32'h8000_0080, 32'h0010_8093, 1'b0);
    consume(1'b0, 32'h0);

    // Redirect coinciding with the response.
    wait_req();
    tick();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_00C0;
    tick();
    redirect_valid_i = 1'b0;
    push(32'h8000_00C0, 32'h0010_C093, 1'b0);
    consume(1'b0, 32'h0);
    push(32'h8000_00C4, 32'h0010_C493, 1'b0);
    rsp_delay = 3;
    consume(1'b0, 32'h0);

    // Two redirects during one long WAIT: the last target wins.
    wait_req();
    tick();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0100;
    tick();
    redirect_pc_i = 32'h8000_0200;
    tick();
    redirect_valid_i = 1'b0; rsp_delay = 0;
    push(32'h8000_0200, 32'h0012_0093, 1'b0);
    rsp_delay = 2;
    consume(1'b0, 32'h0);

    // Reset asserted while WAIT.
    wait_req();
    tick();
    rst = 1'b1;
    #1;
    chk_reset("rst_in_wait");
    rsp_delay = 0;
    tick();
    tick();

    // Ten back-to-back instructions with zero-wait memory and decode.
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      push(32'h8000_0000 + 32'(4 * k), SEQ_DATA[k], 1'b0);
      consume(1'b0, 32'h0);
    end
    chk("steady_cycles", cyc, 31);
`ifdef YSYX_25060170_IFU_PERF_EN
    chk("perf_fetch", perf_fetch_cnt_o, 32'd10);
    chk("perf_stall", perf_stall_cnt_o, 32'd20);
`else
    chk("perf_fetch", perf_fetch_cnt_o, 32'd0);
    chk("perf_stall", perf_stall_cnt_o, 32'd0);
`endif

    tick();
    tick();
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
